muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO result path. It accepts MULT/MULTU/DIV/DIVU requests issued at the EX stage and holds the pipeline with a stall while busy. Division runs as a 32-iteration restoring divider. Completion is a single-cycle 64-bit HI/LO write request that the WB stage forwards to the register file's HI/LO write port.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_ctrl_div_step.sv | 19 +
 rtl/muldiv_ctrl.sv | 127 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings, states and helpers for the mul/div sequencer
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  // Magnitude of a 32-bit operand; 0x80000000 stays 0x80000000 as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// rtl/muldiv_ctrl_div_step.sv - one combinational restoring-division iteration
module div_step (
  input  logic [32:0] rem_in,
  input  logic        dvd_msb,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [34:0] trial;

  assign shifted = {rem_in, dvd_msb};
  assign trial   = {1'b0, shifted} - {3'b000, divisor};
  // A non-negative trial difference means the divisor fits: keep it and emit a 1.
  assign q_bit   = ~trial[34];
  assign rem_out = q_bit ? trial[32:0] : shifted[32:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write
module muldiv_ctrl #(
  parameter int DIV_ITER = muldiv_pkg::DIV_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_result
);
  import muldiv_pkg::*;

  localparam int               CNT_W    = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_mag_q, b_mag_q, quo_q, quo_next;
  logic             sign_a_q, sign_b_q;
  logic [32:0]      rem_q, rem_next;
  logic             q_bit;
  logic [63:0]      hilo_q, product;
  logic             op_signed;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);

  // quo_q starts as the dividend; its MSB feeds each step while quotient bits enter at the LSB.
  div_step u_div_step (
    .rem_in  (rem_q),
    .dvd_msb (quo_q[31]),
    .divisor (b_mag_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign quo_next = {quo_q[30:0], q_bit};
  assign product  = {32'd0, a_mag_q} * {32'd0, b_mag_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    busy    = 1'b0;
    hilo_we = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          stall   = 1'b1;
          state_d = op[1] ? MD_DIV : MD_MUL;
        end
      end
      MD_MUL: begin
        stall   = 1'b1;
        busy    = 1'b1;
        state_d = MD_DONE;
      end
      MD_DIV: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (cnt_q == CNT_LAST) state_d = MD_DONE;
      end
      MD_DONE: begin
        hilo_we = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) begin
      state_d = MD_IDLE;
      hilo_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      hilo_q   <= '0;
    end else if (!flush) begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            a_mag_q  <= mag32(src_a, op_signed);
            b_mag_q  <= mag32(src_b, op_signed);
            sign_a_q <= op_signed & src_a[31];
            sign_b_q <= op_signed & src_b[31];
            quo_q    <= mag32(src_a, op_signed);
            rem_q    <= '0;
            cnt_q    <= '0;
          end
        end
        MD_MUL: begin
          hilo_q <= (sign_a_q ^ sign_b_q) ? (64'd0 - product) : product;
        end
        MD_DIV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          rem_q <= rem_next;
          quo_q <= quo_next;
          // Signed fix-up on the last step: remainder follows the dividend's sign.
          if (cnt_q == CNT_LAST) begin
            hilo_q <= {sign_a_q ? (32'd0 - rem_next[31:0]) : rem_next[31:0],
                       (sign_a_q ^ sign_b_q) ? (32'd0 - quo_next) : quo_next};
          end
        end
        default: ;
      endcase
    end
  end

  assign hilo_result = hilo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed and randomized self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, busy, hilo_we;
  logic [63:0] hilo_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .hilo_we     (hilo_we),
    .hilo_result (hilo_result)
  );

  // Reference: MIPS HI/LO semantics from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [31:0] ma, mb, q, r;
    logic sgn;
    if (o == OP_MULT) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    if (o == OP_MULTU) return {32'd0, a} * {32'd0, b};
    sgn = (o == OP_DIV);
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (mb == 0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after a rising edge with the DUT idle; returns right after the edge following DONE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int lat;
    exp = model(o, a, b);
    lat = o[1] ? 33 : 2;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    check({tag, " c0 stall"}, stall, 1);
    check({tag, " c0 busy"}, busy, 0);
    check({tag, " c0 we"}, hilo_we, 0);
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check({tag, " run busy"}, busy, 1);
      check({tag, " run stall"}, stall, 1);
      check({tag, " run we"}, hilo_we, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, " done we"}, hilo_we, 1);
    check({tag, " done result"}, hilo_result, exp);
    check({tag, " done stall"}, stall, 0);
    check({tag, " done busy"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic we_seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset stall", stall, 0);
    check("reset busy", busy, 0);
    check("reset we", hilo_we, 0);
    check("reset result", hilo_result, 0);
    @(posedge clk); #1;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, "divu_by0");
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min_min");

    // Flush during divide iteration 10, then MULTU two cycles later.
    start = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush div we", hilo_we, 0);
    check("flush div stall", stall, 1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("after flush stall", stall, 0);
    check("after flush busy", busy, 0);
    check("after flush we", hilo_we, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after flush we2", hilo_we, 0);
    @(posedge clk); #1;
    run_op(OP_MULTU, 32'd3, 32'd4, "multu_3x4");

    // Flush in DONE suppresses the write.
    start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush done we", hilo_we, 0);
    check("flush done stall", stall, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("post flush done busy", busy, 0);
    check("post flush done we", hilo_we, 0);
    @(posedge clk); #1;

    // Start together with flush in IDLE is dropped.
    start = 1'b1; flush = 1'b1; op = OP_DIV; src_a = 32'd50; src_b = 32'd5;
    @(negedge clk);
    check("start+flush stall", stall, 0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start+flush busy", busy, 0);
    @(posedge clk); #1;

    // Reset during divide iteration 20, with an ignored start mid-divide.
    we_seen = 1'b0;
    start = 1'b1; op = OP_DIVU; src_a = 32'hFFFF_FFFF; src_b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 5) begin start = 1'b1; op = OP_MULT; src_a = 32'd2; src_b = 32'd2; end
      if (c == 6) start = 1'b0;
      if (c == 21) rst = 1'b1;
      @(negedge clk);
      if (hilo_we) we_seen = 1'b1;
      if (c == 5) begin
        check("ignored start busy", busy, 1);
        check("ignored start stall", stall, 1);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst mid stall", stall, 0);
    check("rst mid busy", busy, 0);
    check("rst mid we", hilo_we, 0);
    check("rst mid result", hilo_result, 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_we) we_seen = 1'b1;
    end
    check("rst no write", we_seen, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = 32'd0;
      if (i % 5 == 1) rb = 32'hFFFF_FFFF;
      if (i % 7 == 3) ra = 32'h8000_0000;
      if (i % 4 == 2) rb = rb >> $urandom_range(8, 28);
      run_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
